// File: rtl/img_rom_arbiter.sv
// Image ROM arbiter: the display has absolute priority; an aux burst reader uses idle ROM cycles.
// Define IMG_ROM_ARB_ABORT_EN to add the aux_abort input for early burst termination.
//
// state | meaning
// IDLE  | waiting for an aux request
// BURST | aux beats issue in every display-free cycle
// DRAIN | last aux beat returns; aux_done pulses
module img_rom_arbiter #(
   parameter int ADDR_W    = 14,
   parameter int DATA_W    = 24,
   parameter int DEPTH     = 10000,
   parameter int LEN_W     = 8,
   parameter int MAX_STALL = 2048
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic              disp_rd_en,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_data,
   input  logic              aux_req,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [LEN_W-1:0]  aux_len,
`ifdef IMG_ROM_ARB_ABORT_EN
   input  logic              aux_abort,
`endif
   output logic              aux_ack,
   output logic              aux_rvalid,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              aux_done,
   output logic              aux_err,
   output logic              aux_stall_err,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rden,
   input  logic [DATA_W-1:0] rom_q
);

   localparam int                STALL_W    = $clog2(MAX_STALL + 1);
   localparam logic [STALL_W-1:0] STALL_SAT  = STALL_W'(MAX_STALL);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MAX_STALL - 1);
   localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]    DEPTH_X    = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t             state_q;
   logic [ADDR_W-1:0]  cur_addr_q;
   logic [LEN_W-1:0]   remaining_q;
   logic [STALL_W-1:0] stall_cnt_q;
   logic               disp_valid_q;
   logic               aux_ack_q;
   logic               aux_err_q;
   logic               aux_done_q;
   logic               aux_rvalid_q;
   logic               aux_stall_err_q;

   logic               abort_w;
   logic               beat_w;
   logic               addr_ok_w;
   logic [ADDR_W-1:0]  cur_addr_d;

`ifdef IMG_ROM_ARB_ABORT_EN
   assign abort_w = aux_abort;
`else
   assign abort_w = 1'b0;
`endif

   assign beat_w     = (state_q == BURST) && !disp_rd_en;
   assign addr_ok_w  = {1'b0, aux_addr} < DEPTH_X;
   assign cur_addr_d = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + 1'b1;

   always_comb begin
      rom_rden = 1'b0;
      rom_addr = '0;
      if (disp_rd_en) begin
         rom_rden = 1'b1;
         rom_addr = disp_addr;
      end else if (state_q == BURST) begin
         rom_rden = 1'b1;
         rom_addr = cur_addr_q;
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q         <= IDLE;
         cur_addr_q      <= '0;
         remaining_q     <= '0;
         stall_cnt_q     <= '0;
         disp_valid_q    <= 1'b0;
         aux_ack_q       <= 1'b0;
         aux_err_q       <= 1'b0;
         aux_done_q      <= 1'b0;
         aux_rvalid_q    <= 1'b0;
         aux_stall_err_q <= 1'b0;
      end else begin
         disp_valid_q <= disp_rd_en;
         aux_ack_q    <= 1'b0;
         aux_err_q    <= 1'b0;
         aux_done_q   <= 1'b0;
         aux_rvalid_q <= beat_w;
         case (state_q)
            IDLE: begin
               // aux_ack_q blocks re-accepting a rejected request still held during its ack cycle
               if (aux_req && !aux_ack_q) begin
                  aux_ack_q <= 1'b1;
                  if (addr_ok_w) begin
                     cur_addr_q      <= aux_addr;
                     remaining_q     <= aux_len;
                     stall_cnt_q     <= '0;
                     aux_stall_err_q <= 1'b0;
                     state_q         <= BURST;
                  end else begin
                     aux_err_q  <= 1'b1;
                     aux_done_q <= 1'b1;
                  end
               end
            end
            BURST: begin
               if (disp_rd_en) begin
                  if (stall_cnt_q != STALL_SAT) stall_cnt_q <= stall_cnt_q + 1'b1;
                  if (stall_cnt_q == STALL_LAST) aux_stall_err_q <= 1'b1;
                  if (abort_w) begin
                     state_q    <= DRAIN;
                     aux_done_q <= 1'b1;
                  end
               end else begin
                  cur_addr_q  <= cur_addr_d;
                  stall_cnt_q <= '0;
                  if (remaining_q == '0 || abort_w) begin
                     state_q    <= DRAIN;
                     aux_done_q <= 1'b1;
                  end else begin
                     remaining_q <= remaining_q - 1'b1;
                  end
               end
            end
            DRAIN:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign disp_valid    = disp_valid_q;
   assign disp_data     = disp_valid_q ? rom_q : '0;
   assign aux_ack       = aux_ack_q;
   assign aux_err       = aux_err_q;
   assign aux_done      = aux_done_q;
   assign aux_rvalid    = aux_rvalid_q;
   assign aux_rdata     = aux_rvalid_q ? rom_q : '0;
   assign aux_stall_err = aux_stall_err_q;

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Directed testbench for img_rom_arbiter with a behavioural 1-cycle-latency ROM.
// Abort scenario is compiled only when IMG_ROM_ARB_ABORT_EN is defined.
module tb_img_rom_arbiter;

   logic        vga_clk;
   logic        sys_rst_n;
   logic        disp_rd_en;
   logic [13:0] disp_addr;
   logic        disp_valid;
   logic [23:0] disp_data;
   logic        aux_req;
   logic [13:0] aux_addr;
   logic [7:0]  aux_len;
`ifdef IMG_ROM_ARB_ABORT_EN
   logic        aux_abort;
`endif
   logic        aux_ack;
   logic        aux_rvalid;
   logic [23:0] aux_rdata;
   logic        aux_done;
   logic        aux_err;
   logic        aux_stall_err;
   logic [13:0] rom_addr;
   logic        rom_rden;
   logic [23:0] rom_q;

   int n_checks = 0;
   int n_pass   = 0;

   img_rom_arbiter dut (
      .vga_clk       (vga_clk),
      .sys_rst_n     (sys_rst_n),
      .disp_rd_en    (disp_rd_en),
      .disp_addr     (disp_addr),
      .disp_valid    (disp_valid),
      .disp_data     (disp_data),
      .aux_req       (aux_req),
      .aux_addr      (aux_addr),
      .aux_len       (aux_len),
`ifdef IMG_ROM_ARB_ABORT_EN
      .aux_abort     (aux_abort),
`endif
      .aux_ack       (aux_ack),
      .aux_rvalid    (aux_rvalid),
      .aux_rdata     (aux_rdata),
      .aux_done      (aux_done),
      .aux_err       (aux_err),
      .aux_stall_err (aux_stall_err),
      .rom_addr      (rom_addr),
      .rom_rden      (rom_rden),
      .rom_q         (rom_q)
   );

   initial begin
      vga_clk = 1'b0;
      forever #5 vga_clk = ~vga_clk;
   end

   function automatic logic [23:0] rom_f(input logic [13:0] a);
      return {10'h2A5, a};
   endfunction

   initial rom_q = '0;
   always @(posedge vga_clk) if (rom_rden) rom_q <= rom_f(rom_addr);

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic test_reset();
      logic [100:0] obs;
      sys_rst_n = 1'b0; disp_rd_en = 1'b0; disp_addr = '0;
      aux_req = 1'b0; aux_addr = '0; aux_len = '0;
`ifdef IMG_ROM_ARB_ABORT_EN
      aux_abort = 1'b0;
`endif
      #2;
      obs = {disp_valid, disp_data, aux_ack, aux_rvalid, aux_rdata, aux_done,
             aux_err, aux_stall_err, rom_addr, rom_rden};
      n_checks++;
      if (obs !== '0) $display("FAIL reset_outputs: got %h, want 0", obs);
      else n_pass++;
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      tick();
      @(negedge vga_clk);
      n_checks++;
      if ({aux_ack, rom_rden, aux_done} !== 3'b000)
         $display("FAIL reset_idle: ack/rden/done=%b, want 000", {aux_ack, rom_rden, aux_done});
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [13:0] exp_addr;
      logic [23:0] exp_rd;
      tick();
      aux_req = 1'b1; aux_addr = 14'd100; aux_len = 8'd3;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) aux_req = 1'b0;
         @(negedge vga_clk);
         exp_addr = (i < 4) ? 14'(100 + i) : 14'd0;
         exp_rd   = (i >= 1 && i <= 4) ? rom_f(14'(100 + i - 1)) : 24'd0;
         n_checks++;
         if ({rom_rden, rom_addr} !== {(i < 4), exp_addr})
            $display("FAIL basic_rom c%0d: rden/addr=%b/%0d, want %b/%0d", i, rom_rden, rom_addr, (i < 4), exp_addr);
         else n_pass++;
         n_checks++;
         if ({aux_ack, aux_rvalid, aux_done} !== {(i == 0), (i >= 1 && i <= 4), (i == 4)})
            $display("FAIL basic_ctl c%0d: ack/rv/done=%b, want %b", i, {aux_ack, aux_rvalid, aux_done},
                     {(i == 0), (i >= 1 && i <= 4), (i == 4)});
         else n_pass++;
         n_checks++;
         if (aux_rdata !== exp_rd) $display("FAIL basic_data c%0d: got %h, want %h", i, aux_rdata, exp_rd);
         else n_pass++;
      end
   endtask

   task automatic test_display_interleave();
      int          exp_rom [0:10] = '{200, 201, 5, 6, 7, 202, 203, 204, 205, 206, 207};
      logic        den     [0:10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
      int          nb = 0;
      logic        exp_dv;
      tick();
      aux_req = 1'b1; aux_addr = 14'd200; aux_len = 8'd7;
      for (int i = 0; i < 13; i++) begin
         tick();
         if (i == 0) aux_req = 1'b0;
         disp_rd_en = (i <= 10) ? den[i] : 1'b0;
         disp_addr  = (i <= 10) ? 14'(exp_rom[i]) : 14'd0;
         @(negedge vga_clk);
         n_checks++;
         if (i <= 10) begin
            if ({rom_rden, rom_addr} !== {1'b1, 14'(exp_rom[i])})
               $display("FAIL mix_rom c%0d: rden/addr=%b/%0d, want 1/%0d", i, rom_rden, rom_addr, exp_rom[i]);
            else n_pass++;
         end else begin
            if (rom_rden !== 1'b0) $display("FAIL mix_rom c%0d: rden=%b, want 0", i, rom_rden);
            else n_pass++;
         end
         exp_dv = (i >= 1 && i <= 11) ? den[i-1] : 1'b0;
         n_checks++;
         if (disp_valid !== exp_dv || (exp_dv && disp_data !== rom_f(14'(exp_rom[i-1]))))
            $display("FAIL mix_disp c%0d: valid/data=%b/%h, want %b", i, disp_valid, disp_data, exp_dv);
         else n_pass++;
         if (aux_rvalid === 1'b1) begin
            n_checks++;
            if (aux_rdata !== rom_f(14'(200 + nb)))
               $display("FAIL mix_beat%0d: got %h, want %h", nb, aux_rdata, rom_f(14'(200 + nb)));
            else n_pass++;
            nb++;
         end
         n_checks++;
         if (aux_done !== (i == 11)) $display("FAIL mix_done c%0d: got %b, want %b", i, aux_done, (i == 11));
         else n_pass++;
      end
      n_checks++;
      if (nb != 8) $display("FAIL mix_beat_count: got %0d, want 8", nb);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int exp_rom [0:3] = '{9998, 9999, 0, 1};
      tick();
      aux_req = 1'b1; aux_addr = 14'd9998; aux_len = 8'd3;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) aux_req = 1'b0;
         @(negedge vga_clk);
         if (i < 4) begin
            n_checks++;
            if (rom_addr !== 14'(exp_rom[i]) || rom_rden !== 1'b1)
               $display("FAIL wrap_addr c%0d: got %0d, want %0d", i, rom_addr, exp_rom[i]);
            else n_pass++;
         end
         if (i > 0) begin
            n_checks++;
            if (aux_rdata !== rom_f(14'(exp_rom[i-1])) || aux_rvalid !== 1'b1)
               $display("FAIL wrap_data c%0d: got %h, want %h", i, aux_rdata, rom_f(14'(exp_rom[i-1])));
            else n_pass++;
         end
         n_checks++;
         if (aux_done !== (i == 4)) $display("FAIL wrap_done c%0d: got %b, want %b", i, aux_done, (i == 4));
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      tick();
      aux_req = 1'b1; aux_addr = 14'd500; aux_len = 8'd0;
      disp_rd_en = 1'b1; disp_addr = 14'd3;
      for (int c = 0; c <= 2050; c++) begin
         tick();
         if (c == 0) aux_req = 1'b0;
         disp_rd_en = (c < 2048);
         @(negedge vga_clk);
         if (c == 0) begin
            n_checks++;
            if ({aux_ack, aux_stall_err} !== 2'b10)
               $display("FAIL stall_accept: ack/err=%b, want 10", {aux_ack, aux_stall_err});
            else n_pass++;
         end
         if (c == 1000) begin
            n_checks++;
            if ({rom_addr, aux_rvalid} !== {14'd3, 1'b0})
               $display("FAIL stall_disp_wins: addr/rv=%0d/%b, want 3/0", rom_addr, aux_rvalid);
            else n_pass++;
         end
         if (c == 2047) begin
            n_checks++;
            if (aux_stall_err !== 1'b0) $display("FAIL stall_early: got %b, want 0", aux_stall_err);
            else n_pass++;
         end
         if (c == 2048) begin
            n_checks++;
            if ({aux_stall_err, rom_rden, rom_addr, aux_rvalid} !== {1'b1, 1'b1, 14'd500, 1'b0})
               $display("FAIL stall_set: err/rden/addr/rv=%b/%b/%0d/%b, want 1/1/500/0",
                        aux_stall_err, rom_rden, rom_addr, aux_rvalid);
            else n_pass++;
         end
         if (c == 2049) begin
            n_checks++;
            if ({aux_rvalid, aux_done, aux_stall_err} !== 3'b111 || aux_rdata !== rom_f(14'd500))
               $display("FAIL stall_beat: rv/done/err=%b data=%h, want 111 %h",
                        {aux_rvalid, aux_done, aux_stall_err}, aux_rdata, rom_f(14'd500));
            else n_pass++;
         end
         if (c == 2050) begin
            n_checks++;
            if ({aux_stall_err, aux_done} !== 2'b10)
               $display("FAIL stall_sticky: err/done=%b, want 10", {aux_stall_err, aux_done});
            else n_pass++;
         end
      end
      aux_req = 1'b1; aux_addr = 14'd600; aux_len = 8'd0;
      tick();
      aux_req = 1'b0;
      @(negedge vga_clk);
      n_checks++;
      if ({aux_ack, aux_stall_err} !== 2'b10)
         $display("FAIL stall_clear: ack/err=%b, want 10", {aux_ack, aux_stall_err});
      else n_pass++;
      tick();
      tick();
   endtask

   task automatic test_illegal_addr();
      logic [13:0] bad [0:1] = '{14'd10000, 14'd16383};
      for (int k = 0; k < 2; k++) begin
         tick();
         aux_req = 1'b1; aux_addr = bad[k]; aux_len = 8'd5;
         for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) aux_req = 1'b0;
            @(negedge vga_clk);
            n_checks++;
            if ({aux_ack, aux_err, aux_done, rom_rden, aux_rvalid} !== {(i == 0), (i == 0), (i == 0), 2'b00})
               $display("FAIL illegal_%0d c%0d: ack/err/done/rden/rv=%b, want %b", bad[k], i,
                        {aux_ack, aux_err, aux_done, rom_rden, aux_rvalid}, {(i == 0), (i == 0), (i == 0), 2'b00});
            else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      tick();
      aux_req = 1'b1; aux_addr = 14'd700; aux_len = 8'd0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 1) aux_addr = 14'd710;
         if (i == 3) aux_req = 1'b0;
         @(negedge vga_clk);
         n_checks++;
         if ({aux_ack, aux_done} !== {(i == 0 || i == 3), (i == 1 || i == 4)})
            $display("FAIL b2b_ctl c%0d: ack/done=%b, want %b", i, {aux_ack, aux_done},
                     {(i == 0 || i == 3), (i == 1 || i == 4)});
         else n_pass++;
         if (i == 3) begin
            n_checks++;
            if ({rom_rden, rom_addr} !== {1'b1, 14'd710})
               $display("FAIL b2b_addr: rden/addr=%b/%0d, want 1/710", rom_rden, rom_addr);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [100:0] obs;
      tick();
      aux_req = 1'b1; aux_addr = 14'd50; aux_len = 8'd200;
      tick();
      aux_req = 1'b0;
      tick();
      tick();
      @(negedge vga_clk);
      n_checks++;
      if ({aux_rvalid, rom_addr} !== {1'b1, 14'd52})
         $display("FAIL rstmid_running: rv/addr=%b/%0d, want 1/52", aux_rvalid, rom_addr);
      else n_pass++;
      #1 sys_rst_n = 1'b0;
      #1;
      obs = {disp_valid, disp_data, aux_ack, aux_rvalid, aux_rdata, aux_done,
             aux_err, aux_stall_err, rom_addr, rom_rden};
      n_checks++;
      if (obs !== '0) $display("FAIL rstmid_outputs: got %h, want 0", obs);
      else n_pass++;
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge vga_clk);
         n_checks++;
         if ({aux_done, rom_rden, aux_rvalid} !== 3'b000)
            $display("FAIL rstmid_idle c%0d: done/rden/rv=%b, want 000", i, {aux_done, rom_rden, aux_rvalid});
         else n_pass++;
      end
   endtask

`ifdef IMG_ROM_ARB_ABORT_EN
   task automatic test_abort();
      tick();
      aux_req = 1'b1; aux_addr = 14'd300; aux_len = 8'd10;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) aux_req = 1'b0;
         aux_abort = (i == 2);
         @(negedge vga_clk);
         n_checks++;
         if ({rom_rden, aux_rvalid, aux_done} !== {(i < 3), (i >= 1 && i <= 3), (i == 3)})
            $display("FAIL abort c%0d: rden/rv/done=%b, want %b", i, {rom_rden, aux_rvalid, aux_done},
                     {(i < 3), (i >= 1 && i <= 3), (i == 3)});
         else n_pass++;
         if (i == 3) begin
            n_checks++;
            if (aux_rdata !== rom_f(14'd302)) $display("FAIL abort_data: got %h, want %h", aux_rdata, rom_f(14'd302));
            else n_pass++;
         end
      end
      aux_abort = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_display_interleave();
      test_wrap();
      test_stall();
      test_illegal_addr();
      test_back_to_back();
`ifdef IMG_ROM_ARB_ABORT_EN
      test_abort();
`endif
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
